// File: rtl/avr_decode_stage.sv
// avr_decode_stage: one-deep decode stage for a small AVR subset.
// Takes a 16-bit fetched word through a valid/ready handshake. It registers
// one decoded bundle: ALU mode, register addresses, immediate, flags and the
// second-word address. It also keeps a saturating count of illegal words.
// Optional feature macro: AVR_DEC_TWO_WORD_EN enables two-word LDS/STS
// handling through an IDLE/WORD2 FSM. When it is undefined, those first
// words decode as illegal.
//
// Handshake: a word is taken on a rising edge when in_valid && in_ready.
// in_ready = !flush && (!out_valid || out_ready). A bundle is consumed when
// out_valid && out_ready. It stays unchanged while out_valid && !out_ready.
module avr_decode_stage #(
  parameter int DMODE_W = 4,
  parameter int K_W     = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DMODE_W-1:0] dmode,
  output logic [4:0]         rd,
  output logic [4:0]         rr,
  output logic [K_W-1:0]     k,
  output logic               use_imm,
  output logic               wb,
  output logic               illegal,
  output logic [15:0]        addr,
  output logic [CNT_W-1:0]   ill_cnt,
  output logic               dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_WORD2 = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [DMODE_W-1:0] dmode_q, dmode_d;
  logic [4:0]         rd_q, rd_d, rr_q, rr_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               use_imm_q, use_imm_d, wb_q, wb_d, illegal_q, illegal_d;
  logic [15:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   ill_cnt_q, ill_cnt_d;
  logic [4:0]         pend_rd_q, pend_rd_d;
  logic               pend_sts_q, pend_sts_d;

  logic       accept;
  logic       first_word;
  logic [3:0] dec_mode;
  logic [4:0] dec_rd, dec_rr;
  logic [7:0] dec_k;
  logic       dec_imm, dec_wb, dec_ill;

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef AVR_DEC_TWO_WORD_EN
  // LDS is 1001000ddddd0000 and STS is 1001001ddddd0000; bit 9 tells them apart.
  assign first_word = (instr[15:10] == 6'b100100) && (instr[3:0] == 4'b0000);
`else
  assign first_word = 1'b0;
`endif

  // Combinational decode of a single-word instruction; illegal by default.
  always_comb begin
    dec_mode = 4'b0010;
    dec_rd   = 5'd0;
    dec_rr   = 5'd0;
    dec_k    = 8'd0;
    dec_imm  = 1'b0;
    dec_wb   = 1'b1;
    dec_ill  = 1'b0;
    case (instr[15:10])
      6'b000000: dec_wb = 1'b0;
      6'b000011: dec_mode = 4'b0000;
      6'b000110: dec_mode = 4'b0001;
      6'b000101: begin dec_mode = 4'b0001; dec_wb = 1'b0; end
      6'b001000: dec_mode = 4'b0100;
      6'b001010: dec_mode = 4'b0101;
      6'b001001: dec_mode = 4'b0110;
      6'b001011: dec_mode = 4'b0010;
      default: begin
        dec_imm = 1'b1;
        case (instr[15:12])
          4'b1110: dec_mode = 4'b0011;
          4'b0101: dec_mode = 4'b0001;
          4'b0011: begin dec_mode = 4'b0001; dec_wb = 1'b0; end
          4'b0111: dec_mode = 4'b0100;
          4'b0110: dec_mode = 4'b0101;
          default: begin dec_ill = 1'b1; dec_wb = 1'b0; dec_imm = 1'b0; end
        endcase
      end
    endcase
    // Register forms use Rd/Rr fields; immediate forms address r16-r31.
    if (!dec_ill) begin
      if (dec_imm) begin
        dec_rd = {1'b1, instr[7:4]};
        dec_k  = {instr[11:8], instr[3:0]};
      end else begin
        dec_rd = {instr[8], instr[7:4]};
        dec_rr = {instr[9], instr[3:0]};
        dec_k  = instr[7:0];
      end
    end
  end

  // Next-state: flush first, then consumer drain, then the accepted word.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    dmode_d     = dmode_q;
    rd_d        = rd_q;
    rr_d        = rr_q;
    k_d         = k_q;
    use_imm_d   = use_imm_q;
    wb_d        = wb_q;
    illegal_d   = illegal_q;
    addr_d      = addr_q;
    ill_cnt_d   = ill_cnt_q;
    pend_rd_d   = pend_rd_q;
    pend_sts_d  = pend_sts_q;
    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (accept) begin
        if (state_q == S_WORD2) begin
          // Second word is a raw address, never decoded.
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          dmode_d     = pend_sts_q ? DMODE_W'(4'b0010) : DMODE_W'(4'b0011);
          wb_d        = !pend_sts_q;
          rd_d        = pend_rd_q;
          rr_d        = 5'd0;
          k_d         = '0;
          use_imm_d   = 1'b0;
          illegal_d   = 1'b0;
          addr_d      = instr;
        end else if (first_word) begin
          state_d    = S_WORD2;
          pend_rd_d  = instr[8:4];
          pend_sts_d = instr[9];
        end else begin
          out_valid_d = 1'b1;
          dmode_d     = DMODE_W'(dec_mode);
          rd_d        = dec_rd;
          rr_d        = dec_rr;
          k_d         = K_W'(dec_k);
          use_imm_d   = dec_imm;
          wb_d        = dec_wb;
          illegal_d   = dec_ill;
          addr_d      = 16'h0000;
          if (dec_ill && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State and bundle registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      dmode_q     <= DMODE_W'(4'b0010);
      rd_q        <= 5'd0;
      rr_q        <= 5'd0;
      k_q         <= '0;
      use_imm_q   <= 1'b0;
      wb_q        <= 1'b0;
      illegal_q   <= 1'b0;
      addr_q      <= 16'h0000;
      ill_cnt_q   <= '0;
      pend_rd_q   <= 5'd0;
      pend_sts_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      dmode_q     <= dmode_d;
      rd_q        <= rd_d;
      rr_q        <= rr_d;
      k_q         <= k_d;
      use_imm_q   <= use_imm_d;
      wb_q        <= wb_d;
      illegal_q   <= illegal_d;
      addr_q      <= addr_d;
      ill_cnt_q   <= ill_cnt_d;
      pend_rd_q   <= pend_rd_d;
      pend_sts_q  <= pend_sts_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dmode     = dmode_q;
  assign rd        = rd_q;
  assign rr        = rr_q;
  assign k         = k_q;
  assign use_imm   = use_imm_q;
  assign wb        = wb_q;
  assign illegal   = illegal_q;
  assign addr      = addr_q;
  assign ill_cnt   = ill_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_avr_decode_stage.sv
// tb_avr_decode_stage: directed vector table plus hand-written sequences
// for backpressure, flush, reset and illegal-counter saturation.
// Honours AVR_DEC_TWO_WORD_EN the same way the design does.
module tb_avr_decode_stage;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] instr, addr;
  logic [3:0]  dmode;
  logic [4:0]  rd, rr;
  logic [7:0]  k, ill_cnt;
  logic        use_imm, wb, illegal, dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int exp_ill = 0;
  logic [13:0] exp_q[$];
  logic [13:0] exp_w;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  dmode;
    logic [4:0]  rd;
    logic [4:0]  rr;
    logic [7:0]  k;
    logic        use_imm;
    logic        wb;
    logic        ill;
    logic        chk_regs;
    logic        chk_rr;
  } vec_t;

  vec_t vecs[15];

  avr_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .dmode(dmode),
    .rd(rd), .rr(rr), .k(k), .use_imm(use_imm), .wb(wb), .illegal(illegal),
    .addr(addr), .ill_cnt(ill_cnt), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one word and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic push(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    instr = w;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: word 0x%0h not accepted in 50 cycles", w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic bump_ill();
    if (exp_ill < 255) exp_ill++;
  endtask

  // One idle cycle with flush asserted while a word is being offered.
  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    instr = 16'h0C12;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_state", dbg_state, 0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_no_accept", out_valid, 0);
  endtask

  task automatic chk_cp(input string tag);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_dmode"}, dmode, 4'b0001);
    chk({tag, "_wb"}, wb, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_ill"}, illegal, 0);
    chk({tag, "_rr"}, rr, 1);
  endtask

  initial begin
    // Instruction, dmode, rd, rr, k, use_imm, wb, illegal, chk_regs, chk_rr
    vecs[0]  = '{16'h0C12, 4'h0, 5'd1,  5'd2,  8'h12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // ADD
    vecs[1]  = '{16'hEA45, 4'h3, 5'd20, 5'd0,  8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // LDI
    vecs[2]  = '{16'h1A3F, 4'h1, 5'd3,  5'd31, 8'h3F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // SUB
    vecs[3]  = '{16'h1401, 4'h1, 5'd0,  5'd1,  8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // CP
    vecs[4]  = '{16'h2145, 4'h4, 5'd20, 5'd5,  8'h45, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // AND
    vecs[5]  = '{16'h2B9C, 4'h5, 5'd25, 5'd28, 8'h9C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // OR
    vecs[6]  = '{16'h2467, 4'h6, 5'd6,  5'd7,  8'h67, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // EOR
    vecs[7]  = '{16'h2C3A, 4'h2, 5'd3,  5'd10, 8'h3A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // MOV
    vecs[8]  = '{16'h0000, 4'h2, 5'd0,  5'd0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // NOP
    vecs[9]  = '{16'h5A7B, 4'h1, 5'd23, 5'd0,  8'hAB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // SUBI
    vecs[10] = '{16'h3F0F, 4'h1, 5'd16, 5'd0,  8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // CPI
    vecs[11] = '{16'h70F0, 4'h4, 5'd31, 5'd0,  8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // ANDI
    vecs[12] = '{16'h6C85, 4'h5, 5'd24, 5'd0,  8'hC5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // ORI
    vecs[13] = '{16'hFFFF, 4'h2, 5'd0,  5'd0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // illegal
    vecs[14] = '{16'h0400, 4'h2, 5'd0,  5'd0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // illegal

    // Reset block.
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = 16'h0000;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dmode", dmode, 4'b0010);
    chk("rst_rd", rd, 0);
    chk("rst_rr", rr, 0);
    chk("rst_k", k, 0);
    chk("rst_flags", {use_imm, wb, illegal}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ill_cnt", ill_cnt, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // LDS r5 then 0x1234.
    push(16'h9050);
`ifdef AVR_DEC_TWO_WORD_EN
    chk("lds_w1_no_out", out_valid, 0);
    chk("lds_w1_state", dbg_state, 1);
    push(16'h1234);
    chk("lds_valid", out_valid, 1);
    chk("lds_addr", addr, 16'h1234);
    chk("lds_rd", rd, 5);
    chk("lds_wb", wb, 1);
    chk("lds_dmode", dmode, 4'b0011);
    chk("lds_ill", illegal, 0);
    chk("lds_state", dbg_state, 0);
    push(16'h9230);
    push(16'hBEEF);
    chk("sts_addr", addr, 16'hBEEF);
    chk("sts_rd", rd, 3);
    chk("sts_wb", wb, 0);
    chk("sts_dmode", dmode, 4'b0010);
`else
    bump_ill();
    chk("lds_ill", illegal, 1);
    chk("lds_ill_wb", wb, 0);
    chk("lds_ill_cnt", ill_cnt, exp_ill);
    chk("lds_state", dbg_state, 0);
`endif

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      push(vecs[i].instr);
      if (vecs[i].ill) bump_ill();
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_dmode", i), dmode, vecs[i].dmode);
      chk($sformatf("v%0d_wb", i), wb, vecs[i].wb);
      chk($sformatf("v%0d_imm", i), use_imm, vecs[i].use_imm);
      chk($sformatf("v%0d_ill", i), illegal, vecs[i].ill);
      chk($sformatf("v%0d_addr", i), addr, 0);
      chk($sformatf("v%0d_ill_cnt", i), ill_cnt, exp_ill);
      if (vecs[i].chk_regs) begin
        chk($sformatf("v%0d_rd", i), rd, vecs[i].rd);
        chk($sformatf("v%0d_k", i), k, vecs[i].k);
      end
      if (vecs[i].chk_rr) chk($sformatf("v%0d_rr", i), rr, vecs[i].rr);
    end

    // Backpressure: the consumer stalls for 3 cycles while the next word waits.
    exp_q.push_back({4'h0, 5'd1, 5'd2});
    exp_q.push_back({4'h1, 5'd3, 5'd31});
    exp_q.push_back({4'h2, 5'd3, 5'd10});
    push(16'h0C12);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 16'h1A3F;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_valid", c), out_valid, 1);
      chk($sformatf("bp%0d_hold", c), {dmode, rd, rr}, exp_q[0]);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    exp_w = exp_q.pop_front();
    chk("bp_first", {dmode, rd, rr}, exp_w);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_w = exp_q.pop_front();
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second", {dmode, rd, rr}, exp_w);
    push(16'h2C3A);
    exp_w = exp_q.pop_front();
    chk("bp_third", {dmode, rd, rr}, exp_w);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Flush with a bundle pending, then CP.
    push(16'h0C12);
    do_flush();
    push(16'h1401);
    chk_cp("cp_after_flush");

`ifdef AVR_DEC_TWO_WORD_EN
    // Flush in WORD2: the following CP must decode as an instruction.
    push(16'h9050);
    chk("w2_state", dbg_state, 1);
    do_flush();
    push(16'h1401);
    chk_cp("cp_after_w2_flush");
    // Reset in WORD2 discards the pending first word.
    push(16'h9050);
    chk("w2r_state", dbg_state, 1);
`endif

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_ill = 0;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_state", dbg_state, 0);
    chk("arst_ill_cnt", ill_cnt, exp_ill);
    chk("arst_dmode", dmode, 4'b0010);
    @(negedge clk);
    rst = 1'b0;
    push(16'h1401);
    chk_cp("cp_after_reset");

    // Saturation of the illegal counter.
    for (int i = 0; i < 300; i++) begin
      push(16'hFFFF);
      bump_ill();
      if (i == 9) chk("sat_mid", ill_cnt, exp_ill);
    end
    chk("sat_final", ill_cnt, exp_ill);
    chk("sat_illegal", illegal, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/avr_decode_stage.md
AVR_DECODE_STAGE -- requirements
Module: avr_decode_stage

Interface
REQ-001 SHALL have parameter DMODE_W, default 4, ALU-mode output width (legal values >=4; upper bits zero-filled).
REQ-002 SHALL have parameter K_W, default 8, immediate output width (legal values >=8; upper bits zero-filled).
REQ-003 SHALL have parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous pipeline flush.
REQ-007 in_valid  input  1  instr holds a valid word.
REQ-008 in_ready  output  1  stage accepts a word this cycle.
REQ-009 instr  input  16  fetched instruction word.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  consumer takes the bundle this cycle.
REQ-012 dmode  output  DMODE_W  ALU operation.
REQ-013 rd, rr  output  5 each  destination and source register addresses.
REQ-014 k  output  K_W  immediate.
REQ-015 use_imm, wb, illegal  output  1 each  B operand is k; write Rd; undecodable word.
REQ-016 addr  output  16  second word of a two-word instruction, else 0.
REQ-017 ill_cnt  output  CNT_W  count of illegal words, saturating.

Function
REQ-018 SHALL accept a word when in_valid && in_ready, where in_ready = !flush && (!out_valid || out_ready).
REQ-019 SHALL present a single-word instruction's bundle one cycle after acceptance and hold it unchanged while out_valid && !out_ready.
REQ-020 SHALL decode on instr[15:10] as follows, with Rr = {i[9],i[3:0]}, Rd = {i[8],i[7:4]}, k = i[7:0], wb=1 unless stated:
  000000 NOP: dmode=0010, wb=0.
  000011 ADD: dmode=0000.
  000110 SUB: dmode=0001.
  000101 CP: dmode=0001, wb=0.
  001000 AND: dmode=0100.
  001010 OR: dmode=0101.
  001001 EOR: dmode=0110.
  001011 MOV: dmode=0010.
REQ-021 SHALL decode immediate forms on i[15:12] with Rd = {1,i[7:4]} (r16-r31), k = {i[11:8],i[3:0]}, use_imm=1:
  1110 LDI: dmode=0011.
  0101 SUBI: dmode=0001.
  0011 CPI: dmode=0001, wb=0.
  0111 ANDI: dmode=0100.
  0110 ORI: dmode=0101.
REQ-022 SHALL treat any other word as illegal: illegal=1, dmode=0010, wb=0, use_imm=0. ill_cnt increments by 1 when the word is accepted and saturates at all-ones.
REQ-023 SHALL implement FSM IDLE/WORD2: IDLE->WORD2 on accepting an LDS (1001000ddddd0000) or STS (1001001ddddd0000) first word, with no output produced; WORD2->IDLE on accepting the next word, which SHALL be captured into addr and SHALL produce the bundle (LDS: dmode=0011, wb=1; STS: dmode=0010, wb=0; Rd from word 1). The second word SHALL never be decoded as an instruction.
REQ-024 flush SHALL clear out_valid, return the FSM to IDLE and block acceptance in that cycle; flush SHALL take priority over a simultaneous accept or out_ready.
REQ-025 SHALL drive addr=0 for all single-word bundles.

Reset
REQ-026 rst SHALL immediately force state=IDLE, out_valid=0, dmode=0010, rd=rr=0, k=0, use_imm=wb=illegal=0, addr=0, ill_cnt=0.
REQ-027 rst asserted in WORD2 SHALL discard the pending first word.

Configuration
REQ-028 Macro AVR_DEC_TWO_WORD_EN: when defined, REQ-023 applies. When undefined, the SHALL FSM stay in IDLE and LDS/STS first words SHALL be decoded as illegal per REQ-022.

Verification
REQ-029 Reset, then ADD r1,r2 (0x0C12) -> one cycle later out_valid=1, dmode=0000, rd=1, rr=2, wb=1, use_imm=0.
REQ-030 LDI r20,0xA5 (0xEA45) -> rd=20, k=0xA5, dmode=0011, use_imm=1.
REQ-031 With macro defined, LDS r5 (0x9050) then 0x1234 -> single bundle with addr=0x1234, rd=5, wb=1. Without the macro -> illegal=1, ill_cnt=1.
REQ-032 out_ready=0 for 3 cycles with back-to-back words -> in_ready=0, bundle stable, no word lost.
REQ-033 0xFFFF issued 300 times with CNT_W=8 -> ill_cnt=255.
REQ-034 flush asserted while in WORD2 -> out_valid=0. Then CP 0x1401 -> dmode=0001, wb=0, addr=0.
